// File: rtl/fir_capture_pkg.sv
// Purpose: shared types and constants for the FIR capture buffer slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package fir_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } capture_state_t;

   localparam logic TRIG_IMMEDIATE = 1'b0;
   localparam logic TRIG_RISING    = 1'b1;

   typedef logic signed [13:0] sample_t;

endpackage

// File: rtl/capture_ram_sdp.sv
// Purpose: simple dual-port sample memory, one write port and one read port.
// Latency: read data registered, valid one cycle after rd_en; read-first on address collision.
// Backpressure: none; both ports accept an access every cycle.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_dat write port
//   rd_en/rd_addr       read request
//   rd_dat              registered read data, holds its value when rd_en is low
module capture_ram_sdp
   import fir_capture_pkg::*;
#(
   parameter int DATA_WIDTH = 14,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_dat,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_dat
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Memory array is never reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   // Non-blocking read of the array sees the pre-write contents: read-first.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_dat <= '0;
      end else if (rd_en) begin
         rd_dat <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/fir_capture_buffer.sv
// Purpose: triggered, decimated capture of the FIR sample stream into RAM with a read-back port.
// Latency: trigger sample written the cycle it arrives; rd_data/rd_valid one cycle after rd_en.
// Backpressure: none; s_valid samples arriving outside ARMED/CAPTURE are dropped.
//
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   s_data, s_valid               filtered sample stream
//   arm, abort                    capture control pulses (abort wins)
//   trig_mode, trig_level, decim, capture_len   capture setup, latched on arm
//   rd_en, rd_addr, rd_data, rd_valid           memory read-back
//   busy, done, wr_count          status
module fir_capture_buffer
   import fir_capture_pkg::*;
#(
   parameter int DATA_WIDTH  = 14,
   parameter int DEPTH       = 1024,
   parameter int ADDR_WIDTH  = $clog2(DEPTH),
   parameter int DECIM_WIDTH = 16
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic signed [DATA_WIDTH-1:0] s_data,
   input  logic                         s_valid,
   input  logic                         arm,
   input  logic                         abort,
   input  logic                         trig_mode,
   input  logic signed [DATA_WIDTH-1:0] trig_level,
   input  logic [DECIM_WIDTH-1:0]       decim,
   input  logic [ADDR_WIDTH:0]          capture_len,
   input  logic                         rd_en,
   input  logic [ADDR_WIDTH-1:0]        rd_addr,
   output logic [DATA_WIDTH-1:0]        rd_data,
   output logic                         rd_valid,
   output logic                         busy,
   output logic                         done,
   output logic [ADDR_WIDTH:0]          wr_count
);

   localparam logic [ADDR_WIDTH:0] DEPTH_LEN = (ADDR_WIDTH+1)'(DEPTH);

   capture_state_t                 state_q, state_d;
   logic [ADDR_WIDTH:0]            len_q, len_clamped, wr_count_q, wr_count_inc;
   logic [DECIM_WIDTH-1:0]         decim_q, dcnt_q;
   logic                           mode_q;
   logic signed [DATA_WIDTH-1:0]   level_q, prev_q;
   logic                           prev_vld_q;
   logic                           trig_hit, wr_en, rd_valid_q;
   logic [ADDR_WIDTH-1:0]          wr_addr;

   // 0 and anything beyond the memory both mean "fill the whole memory".
   assign len_clamped  = (capture_len == '0 || capture_len > DEPTH_LEN) ? DEPTH_LEN : capture_len;
   assign wr_count_inc = wr_count_q + 1'b1;

   // Trigger and write strobe for the current sample.
   always_comb begin
      trig_hit = (mode_q == TRIG_IMMEDIATE) ||
                 ((mode_q == TRIG_RISING) && prev_vld_q &&
                  (prev_q < level_q) && (s_data >= level_q));
      wr_en   = 1'b0;
      wr_addr = wr_count_q[ADDR_WIDTH-1:0];
      if (s_valid && !abort) begin
         case (state_q)
            ARMED: begin
               wr_en   = trig_hit;
               wr_addr = '0;
            end
            CAPTURE: wr_en = (dcnt_q == decim_q);
            default: wr_en = 1'b0;
         endcase
      end
   end

   // FSM: state register.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: if (arm) state_d = ARMED;
            ARMED:      if (wr_en) state_d = (len_q == 1) ? DONE : CAPTURE;
            CAPTURE:    if (wr_en && wr_count_inc == len_q) state_d = DONE;
            default:    state_d = IDLE;
         endcase
      end
   end

   // FSM: outputs.
   always_comb begin
      busy = (state_q == ARMED) || (state_q == CAPTURE);
      done = (state_q == DONE);
   end

   // Latched setup, counters and trigger history.
   always_ff @(posedge aclk) begin
      if (areset) begin
         len_q      <= DEPTH_LEN;
         decim_q    <= '0;
         mode_q     <= TRIG_IMMEDIATE;
         level_q    <= '0;
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         dcnt_q     <= '0;
         wr_count_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (!abort) begin
            if ((state_q == IDLE || state_q == DONE) && arm) begin
               len_q      <= len_clamped;
               decim_q    <= decim;
               mode_q     <= trig_mode;
               level_q    <= trig_level;
               prev_vld_q <= 1'b0;
               wr_count_q <= '0;
            end else if (state_q == ARMED && s_valid) begin
               prev_q     <= s_data;
               prev_vld_q <= 1'b1;
               if (wr_en) begin
                  wr_count_q <= (ADDR_WIDTH+1)'(1);
                  dcnt_q     <= '0;
               end
            end else if (state_q == CAPTURE && s_valid) begin
               if (wr_en) begin
                  wr_count_q <= wr_count_inc;
                  dcnt_q     <= '0;
               end else begin
                  dcnt_q <= dcnt_q + 1'b1;
               end
            end
         end
      end
   end

   assign wr_count = wr_count_q;
   assign rd_valid = rd_valid_q;

   capture_ram_sdp #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (aclk),
      .rst     (areset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_dat  (s_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_dat  (rd_data)
   );

endmodule

// File: tb/tb_fir_capture_buffer.sv
module tb_fir_capture_buffer;

   logic               aclk = 1'b0;
   logic               areset;
   logic signed [13:0] s_data;
   logic               s_valid;
   logic               arm;
   logic               abort;
   logic               trig_mode;
   logic signed [13:0] trig_level;
   logic [15:0]        decim;
   logic [10:0]        capture_len;
   logic               rd_en;
   logic [9:0]         rd_addr;
   logic [13:0]        rd_data;
   logic               rd_valid;
   logic               busy;
   logic               done;
   logic [10:0]        wr_count;

   int checks   = 0;
   int failures = 0;
   logic [13:0] exp_q[$];

   always #5 aclk = ~aclk;

   fir_capture_buffer dut (
      .aclk        (aclk),
      .areset      (areset),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .arm         (arm),
      .abort       (abort),
      .trig_mode   (trig_mode),
      .trig_level  (trig_level),
      .decim       (decim),
      .capture_len (capture_len),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .busy        (busy),
      .done        (done),
      .wr_count    (wr_count)
   );

   initial begin
      #1ms;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic [13:0] v);
      s_data  = v;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic arm_cfg(input logic mode, input logic [13:0] lvl,
                          input logic [15:0] dec, input logic [10:0] len);
      trig_mode   = mode;
      trig_level  = lvl;
      decim       = dec;
      capture_len = len;
      arm         = 1'b1;
      tick();
      arm         = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic read_word(input logic [9:0] a, output logic [13:0] d, output logic v);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en   = 1'b0;
      d       = rd_data;
      v       = rd_valid;
   endtask

   task automatic test_reset();
      areset = 1'b1; s_valid = 1'b0; s_data = '0; arm = 1'b0; abort = 1'b0;
      trig_mode = 1'b0; trig_level = '0; decim = '0; capture_len = '0;
      rd_en = 1'b0; rd_addr = '0;
      tick(); tick();
      areset = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || wr_count !== 11'd0 || rd_data !== 14'd0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%0b done=%0b rd_valid=%0b wr_count=%0d rd_data=%0d exp all 0",
                  busy, done, rd_valid, wr_count, rd_data);
      end
   endtask

   task automatic test_immediate();
      logic [13:0] d, e; logic v;
      exp_q.delete();
      arm_cfg(1'b0, 14'd0, 16'd0, 11'd8);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL imm_busy_after_arm got=%0b exp=1", busy); end
      for (int i = 0; i < 16; i++) begin
         send(14'(100 + i));
         if (i < 8) exp_q.push_back(14'(100 + i));
         if (i == 6) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               failures++; $display("FAIL imm_busy_before_last got busy=%0b done=%0b exp busy=1 done=0", busy, done);
            end
         end
         if (i == 7) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b1) begin
               failures++; $display("FAIL imm_done_after_last got busy=%0b done=%0b exp busy=0 done=1", busy, done);
            end
         end
      end
      checks++;
      if (wr_count !== 11'd8) begin failures++; $display("FAIL imm_wr_count got=%0d exp=8", wr_count); end
      for (int i = 0; i < 8; i++) begin
         read_word(10'(i), d, v);
         e = exp_q.pop_front();
         checks++;
         if (v !== 1'b1 || d !== e) begin
            failures++; $display("FAIL imm_read addr=%0d got=%0d vld=%0b exp=%0d", i, d, v, e);
         end
      end
   endtask

   task automatic test_level();
      int lv[7] = '{-3, -2, -1, 0, 1, 2, 3};
      logic [13:0] d, e; logic v;
      exp_q.delete();
      arm_cfg(1'b1, 14'd0, 16'd0, 11'd4);
      for (int i = 0; i < 7; i++) begin
         send(14'(lv[i]));
         if (i >= 3) exp_q.push_back(14'(lv[i]));
         tick();
         if (i == 5) begin
            checks++;
            if (busy !== 1'b1 || wr_count !== 11'd3) begin
               failures++; $display("FAIL lvl_before_fourth got busy=%0b wr_count=%0d exp busy=1 wr_count=3", busy, wr_count);
            end
         end
      end
      checks++;
      if (done !== 1'b1 || wr_count !== 11'd4) begin
         failures++; $display("FAIL lvl_done got done=%0b wr_count=%0d exp done=1 wr_count=4", done, wr_count);
      end
      for (int i = 0; i < 4; i++) begin
         read_word(10'(i), d, v);
         e = exp_q.pop_front();
         checks++;
         if (v !== 1'b1 || d !== e) begin
            failures++; $display("FAIL lvl_read addr=%0d got=%0d vld=%0b exp=%0d", i, $signed(d), v, $signed(e));
         end
      end
      // A first sample already at the level only seeds the history.
      arm_cfg(1'b1, 14'd0, 16'd0, 11'd4);
      send(14'd0); tick();
      send(14'd5); tick();
      checks++;
      if (wr_count !== 11'd0 || busy !== 1'b1) begin
         failures++; $display("FAIL lvl_no_first_trigger got wr_count=%0d busy=%0b exp wr_count=0 busy=1", wr_count, busy);
      end
      send(14'h3FFF); send(14'd0);
      checks++;
      if (wr_count !== 11'd1) begin failures++; $display("FAIL lvl_late_trigger got=%0d exp=1", wr_count); end
      pulse_abort();
   endtask

   task automatic test_decim();
      logic [13:0] d, e; logic v;
      exp_q.delete();
      arm_cfg(1'b0, 14'd0, 16'd2, 11'd4);
      for (int i = 0; i <= 20; i++) begin
         send(14'(i));
         if (i % 3 == 0 && i <= 9) exp_q.push_back(14'(i));
      end
      checks++;
      if (done !== 1'b1 || wr_count !== 11'd4) begin
         failures++; $display("FAIL dec_done got done=%0b wr_count=%0d exp done=1 wr_count=4", done, wr_count);
      end
      for (int i = 0; i < 4; i++) begin
         read_word(10'(i), d, v);
         e = exp_q.pop_front();
         checks++;
         if (v !== 1'b1 || d !== e) begin
            failures++; $display("FAIL dec_read addr=%0d got=%0d vld=%0b exp=%0d", i, d, v, e);
         end
      end
   endtask

   task automatic test_abort();
      logic [13:0] d, e; logic v;
      exp_q.delete();
      arm_cfg(1'b0, 14'd0, 16'd0, 11'd16);
      for (int i = 0; i < 4; i++) begin
         send(14'(200 + i));
         exp_q.push_back(14'(200 + i));
      end
      // Fifth sample goes to address 4 while address 4 is read: old contents expected.
      s_data = 14'd204; s_valid = 1'b1; rd_en = 1'b1; rd_addr = 10'd4;
      tick();
      s_valid = 1'b0; rd_en = 1'b0;
      exp_q.push_back(14'd204);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 14'd104) begin
         failures++; $display("FAIL read_first got=%0d vld=%0b exp=104", rd_data, rd_valid);
      end
      pulse_abort();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || wr_count !== 11'd5) begin
         failures++; $display("FAIL abort_state got busy=%0b done=%0b wr_count=%0d exp 0 0 5", busy, done, wr_count);
      end
      for (int i = 0; i < 5; i++) begin
         read_word(10'(i), d, v);
         e = exp_q.pop_front();
         checks++;
         if (v !== 1'b1 || d !== e) begin
            failures++; $display("FAIL abort_read addr=%0d got=%0d vld=%0b exp=%0d", i, d, v, e);
         end
      end
      arm_cfg(1'b0, 14'd0, 16'd0, 11'd16);
      checks++;
      if (wr_count !== 11'd0 || busy !== 1'b1) begin
         failures++; $display("FAIL rearm got wr_count=%0d busy=%0b exp wr_count=0 busy=1", wr_count, busy);
      end
      pulse_abort();
   endtask

   task automatic test_len_zero();
      int addrs[3] = '{0, 511, 1023};
      int tmp;
      logic [13:0] d, e; logic v;
      exp_q.delete();
      arm_cfg(1'b0, 14'd0, 16'd0, 11'd0);
      for (int i = 0; i < 1030; i++) begin
         tmp = i * 7 - 3000;
         send(tmp[13:0]);
         if (i == 0 || i == 511 || i == 1023) exp_q.push_back(tmp[13:0]);
         if (i == 1022) begin
            checks++;
            if (busy !== 1'b1 || wr_count !== 11'd1023) begin
               failures++; $display("FAIL len0_before_last got busy=%0b wr_count=%0d exp busy=1 wr_count=1023", busy, wr_count);
            end
         end
         if (i == 1023) begin
            checks++;
            if (done !== 1'b1 || wr_count !== 11'd1024) begin
               failures++; $display("FAIL len0_done got done=%0b wr_count=%0d exp done=1 wr_count=1024", done, wr_count);
            end
         end
      end
      checks++;
      if (wr_count !== 11'd1024) begin failures++; $display("FAIL len0_hold got=%0d exp=1024", wr_count); end
      for (int i = 0; i < 3; i++) begin
         read_word(10'(addrs[i]), d, v);
         e = exp_q.pop_front();
         checks++;
         if (v !== 1'b1 || d !== e) begin
            failures++; $display("FAIL len0_read addr=%0d got=%0d vld=%0b exp=%0d", addrs[i], d, v, e);
         end
      end
   endtask

   task automatic test_arm_busy();
      logic [13:0] d, e; logic v;
      exp_q.delete();
      arm_cfg(1'b0, 14'd0, 16'd0, 11'd4);
      send(14'd10); send(14'd11);
      exp_q.push_back(14'd10); exp_q.push_back(14'd11);
      arm_cfg(1'b1, 14'd500, 16'd5, 11'd2);
      checks++;
      if (busy !== 1'b1 || wr_count !== 11'd2) begin
         failures++; $display("FAIL arm_busy_ignored got busy=%0b wr_count=%0d exp busy=1 wr_count=2", busy, wr_count);
      end
      send(14'd12); send(14'd13);
      exp_q.push_back(14'd12); exp_q.push_back(14'd13);
      checks++;
      if (done !== 1'b1 || wr_count !== 11'd4) begin
         failures++; $display("FAIL arm_busy_done got done=%0b wr_count=%0d exp done=1 wr_count=4", done, wr_count);
      end
      for (int i = 0; i < 4; i++) begin
         read_word(10'(i), d, v);
         e = exp_q.pop_front();
         checks++;
         if (v !== 1'b1 || d !== e) begin
            failures++; $display("FAIL arm_busy_read addr=%0d got=%0d vld=%0b exp=%0d", i, d, v, e);
         end
      end
   endtask

   task automatic test_arm_abort();
      arm = 1'b1; abort = 1'b1;
      tick();
      arm = 1'b0; abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || wr_count !== 11'd4) begin
         failures++; $display("FAIL arm_abort got busy=%0b done=%0b wr_count=%0d exp 0 0 4", busy, done, wr_count);
      end
      send(14'd50);
      checks++;
      if (busy !== 1'b0 || wr_count !== 11'd4) begin
         failures++; $display("FAIL idle_ignores got busy=%0b wr_count=%0d exp busy=0 wr_count=4", busy, wr_count);
      end
   endtask

   task automatic test_reset_mid();
      logic [13:0] d, e; logic v;
      exp_q.delete();
      arm_cfg(1'b0, 14'd0, 16'd0, 11'd8);
      send(14'd300); send(14'd301); send(14'd302);
      exp_q.push_back(14'd300);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || wr_count !== 11'd0 || rd_data !== 14'd0) begin
         failures++;
         $display("FAIL reset_mid got busy=%0b done=%0b rd_valid=%0b wr_count=%0d rd_data=%0d exp all 0",
                  busy, done, rd_valid, wr_count, rd_data);
      end
      read_word(10'd0, d, v);
      e = exp_q.pop_front();
      checks++;
      if (v !== 1'b1 || d !== e) begin
         failures++; $display("FAIL reset_mid_read got=%0d vld=%0b exp=%0d", d, v, e);
      end
      tick();
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== 14'd300) begin
         failures++; $display("FAIL rd_hold got=%0d vld=%0b exp=300 vld=0", rd_data, rd_valid);
      end
   endtask

   initial begin
      test_reset();
      test_immediate();
      test_level();
      test_decim();
      test_abort();
      test_len_zero();
      test_arm_busy();
      test_arm_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fir_capture_buffer.md
Name: fir_capture_buffer

Overview:
- Downstream stage of axi_fir32_14b: consumes the filtered 14-bit sample stream and captures a triggered window of samples into block RAM.
- Captured samples are read back through a simple synchronous read port that the AXI-Lite register block maps for the PetaLinux driver.
- Supports software arm/abort, immediate or rising-level trigger, and sample decimation.

Parameters:
- DATA_WIDTH, 14, sample width; signed two's complement, matches FIR output.
- DEPTH, 1024, capture memory depth in samples; power of two.
- ADDR_WIDTH, $clog2(DEPTH), read/write address width (derived).
- DECIM_WIDTH, 16, width of decimation control.

Ports:
- aclk  in  1  system clock, all logic rising-edge.
- areset  in  1  synchronous reset, active-high.
- s_data  in  DATA_WIDTH  FIR output sample, signed.
- s_valid  in  1  s_data valid strobe, one cycle per sample; no backpressure.
- arm  in  1  single-cycle pulse that starts a capture.
- abort  in  1  single-cycle pulse that cancels a capture.
- trig_mode  in  1  0 = immediate, 1 = rising level crossing.
- trig_level  in  DATA_WIDTH  signed trigger threshold.
- decim  in  DECIM_WIDTH  store one of every decim+1 valid samples.
- capture_len  in  ADDR_WIDTH+1  samples to store; 0 or >DEPTH means DEPTH.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data qualifier.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- wr_count  out  ADDR_WIDTH+1  samples stored in current/last capture.

Behaviour:
- Reset: FSM=IDLE; busy, done, rd_valid, wr_count, rd_data all 0; decimation counter 0; prev-sample flag cleared. Memory contents are not reset.
- Clock/reset: one clock, aclk; reset areset is synchronous and active-high.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
- IDLE/DONE + arm -> ARMED:
  - latch capture_len (with 0/oversize clamped to DEPTH), decim, trig_mode, trig_level;
  - clear wr_count and prev-valid flag; done drops the next cycle.
- arm while busy is ignored.
- ARMED, trig_mode=0: first s_valid sample is the trigger.
- ARMED, trig_mode=1:
  - the first s_valid sample after arm only loads prev;
  - trigger on a later valid sample where prev < trig_level and s_data >= trig_level (signed compare);
  - prev updates on every valid sample.
- Trigger sample is written to address 0 in the same cycle; FSM -> CAPTURE; wr_count=1; decimation counter reset to 0.
- If latched len=1, go straight to DONE.
- CAPTURE, per s_valid:
  - if decim counter == latched decim: write sample at address wr_count, increment wr_count, counter -> 0;
  - otherwise increment counter.
  - With decim=0, every valid sample is stored.
- When wr_count reaches latched len (on the cycle of the final write), FSM -> DONE. done=1 and busy=0 from the following cycle.
- abort in any state -> IDLE next cycle; busy=0, done=0; wr_count holds the partial count. abort has priority over arm and trigger in the same cycle.
- Changes to control inputs during a capture have no effect (latched at arm).
- Read port:
  - rd_en at cycle N gives rd_data and rd_valid=1 at cycle N+1; rd_valid=0 otherwise, and rd_data holds its last value.
  - Reads are allowed in any state.
  - A same-cycle read and write to one address returns the old contents (read-first).
- Memory is simple dual-port, inferable as BRAM: write port on the FSM, read port on rd_*.
- wr_count never exceeds DEPTH; write address is wr_count[ADDR_WIDTH-1:0].

Decomposition:
- Package fir_capture_pkg:
  - typedef enum capture_state_t {IDLE, ARMED, CAPTURE, DONE};
  - localparams TRIG_IMMEDIATE=1'b0 and TRIG_RISING=1'b1;
  - typedef sample_t = logic signed [13:0].
- Sub-module capture_ram_sdp (parameterised by DATA_WIDTH/DEPTH): simple dual-port, read-first, registered read. The top holds the FSM, trigger compare, decimator and counters.

Test Plan:
- Immediate capture: reset, capture_len=8, decim=0, mode 0, arm, then feed ramp 100..115 valid every cycle -> done after 8 samples; reads of 0..7 return 100..107; wr_count=8.
- Level trigger: mode 1, level=0, feed -3,-2,-1,0,1,2 (valid every 2nd cycle), len=4 -> addr0=0, addr1=1, addr2=2; busy stays high until the 4th sample; a sample already at 0 on the first valid does not trigger.
- Decimation: decim=2, len=4, ramp 0..20 immediate -> stored 0,3,6,9; done=1.
- Abort: len=16, abort after 5 stored samples -> busy=0, done=0, wr_count=5 next cycle; a later arm restarts with wr_count=0.
- Boundaries: capture_len=0 -> captures 1024 samples; wr_count=1024, address wraps never; arm while busy has no effect; arm+abort same cycle -> IDLE.
- Reset mid-capture: assert areset after 3 samples -> all outputs 0 next cycle; rd_en then rd_valid=1 one cycle later.
